// File: rtl/pkt_cls_pkg.sv
// Shared constants and types for the packet header classifier.
// Byte offsets are counted from the start of the Ethernet frame in beat 0.
package pkt_cls_pkg;

   localparam int OFS_ETHERTYPE = 12;
   localparam int OFS_TOS       = 15;
   localparam int OFS_IPLEN     = 16;
   localparam int OFS_PROTO     = 23;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IPPROTO_TCP    = 8'h06;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } cls_state_t;

   // Everything decided from beat 0 that has to travel with the packet
   typedef struct packed {
      logic        ipv4;
      logic        need_decomp;
      logic [15:0] length;
   } hdr_info_t;

   // End-of-packet record; the burst/beat counts sit beside it in the top
   // because their width is a parameter of that module.
   typedef struct packed {
      logic        need_decomp;
      logic        len_err;
      logic [15:0] length;
   } meta_rec_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/pkt_cls_hdr_decode.sv
// Combinational decode of beat 0: IPv4 detection, decompress match and
// frame length (IPv4 total length plus Ethernet header, saturating).
module pkt_cls_hdr_decode
   import pkt_cls_pkg::*;
#(
   parameter int DATA_W      = 256,
   parameter int MATCH_IPLEN = 1500,
   parameter int FRAME_ADJ   = 14
) (
   input  logic [DATA_W-1:0] beat_data,
   output hdr_info_t         hdr
);

   logic [15:0] ethertype;
   logic [7:0]  tos;
   logic [15:0] iplen;
   logic [7:0]  proto;
   logic        ipv4;
   logic        unused_bits;

   assign ethertype = {beat_data[8*OFS_ETHERTYPE +: 8], beat_data[8*(OFS_ETHERTYPE+1) +: 8]};
   assign tos       = beat_data[8*OFS_TOS +: 8];
   assign iplen     = {beat_data[8*OFS_IPLEN +: 8], beat_data[8*(OFS_IPLEN+1) +: 8]};
   assign proto     = beat_data[8*OFS_PROTO +: 8];
   assign ipv4      = (ethertype == ETHERTYPE_IPV4);

   // Most of the beat is payload the classifier never looks at
   assign unused_bits = ^beat_data;

   // Field match and saturating length for the header record
   always_comb begin
      hdr             = '0;
      hdr.ipv4        = ipv4;
      hdr.need_decomp = ipv4 && (tos != 8'h00) && (proto == IPPROTO_TCP)
                        && (iplen == 16'(MATCH_IPLEN));
      hdr.length      = ipv4 ? sat_add16(iplen, 16'(FRAME_ADJ)) : 16'h0000;
   end

endmodule

// File: rtl/pkt_header_classifier.sv
// Passive AXI4-Stream tap that classifies each Ethernet/IPv4 packet on its
// first beat, pulses an early header result and queues a one-entry
// end-of-packet metadata record. Never drives s_tready.
// Optional statistics counters: define PKT_CLS_STATS_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | next fired beat is beat 0 of a new packet
//   ST_BODY | inside a packet, counting beats until the tlast beat
module pkt_header_classifier
   import pkt_cls_pkg::*;
#(
   parameter int DATA_W      = 256,
   parameter int BURST_BYTES = 32,
   parameter int CNT_W       = 16,
   parameter int MATCH_IPLEN = 1500,
   parameter int FRAME_ADJ   = 14
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              s_tvalid,
   input  logic              s_tready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tlast,
   output logic              hdr_valid,
   output logic              hdr_need_decomp,
   output logic [15:0]       hdr_length,
   output logic              meta_valid,
   input  logic              meta_ready,
   output logic              meta_need_decomp,
   output logic [15:0]       meta_length,
   output logic [CNT_W-1:0]  meta_bursts,
   output logic [CNT_W-1:0]  meta_beats,
   output logic              meta_len_err,
   output logic              meta_drop,
   output logic [31:0]       stat_pkts,
   output logic [31:0]       stat_decomp,
   output logic [31:0]       stat_lenerr
);

   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int BURST_SH   = $clog2(BURST_BYTES);

   cls_state_t        state;
   hdr_info_t         dec_hdr;
   hdr_info_t         pkt_hdr;
   hdr_info_t         fin_hdr;
   logic [CNT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]  fin_beats;
   logic [16:0]       fin_bursts17;
   logic [16:0]       fin_exp_beats17;
   logic              fin_len_err;
   logic              fire;
   logic              beat0;
   logic              fin;
   logic              meta_load;
   meta_rec_t         meta_q;

   assign fire  = s_tvalid && s_tready;
   assign beat0 = fire && (state == ST_IDLE);
   assign fin   = fire && s_tlast;

   pkt_cls_hdr_decode #(
      .DATA_W      (DATA_W),
      .MATCH_IPLEN (MATCH_IPLEN),
      .FRAME_ADJ   (FRAME_ADJ)
   ) u_hdr_decode (
      .beat_data (s_tdata),
      .hdr       (dec_hdr)
   );

   // A single-beat packet finalizes straight from the decoder, so the
   // record source and the running count both depend on the state.
   always_comb begin
      fin_hdr   = pkt_hdr;
      fin_beats = beat_cnt;
      if (state == ST_IDLE) begin
         fin_hdr   = dec_hdr;
         fin_beats = CNT_W'(1);
      end else if (beat_cnt != '1) begin
         fin_beats = beat_cnt + CNT_W'(1);
      end
   end

   // Burst and expected-beat rounding is done at 17 bits so a saturated
   // 0xFFFF length cannot wrap.
   assign fin_bursts17    = ({1'b0, fin_hdr.length} + 17'(BURST_BYTES - 1)) >> BURST_SH;
   assign fin_exp_beats17 = ({1'b0, fin_hdr.length} + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES);
   assign fin_len_err     = fin_hdr.ipv4 && (32'(fin_beats) != 32'(fin_exp_beats17));

   // Packet FSM, beat counter and the early header pulse
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state           <= ST_IDLE;
         pkt_hdr         <= '0;
         beat_cnt        <= '0;
         hdr_valid       <= 1'b0;
         hdr_need_decomp <= 1'b0;
         hdr_length      <= 16'h0000;
      end else begin
         hdr_valid <= beat0;
         if (beat0) begin
            pkt_hdr         <= dec_hdr;
            hdr_need_decomp <= dec_hdr.need_decomp;
            hdr_length      <= dec_hdr.length;
         end
         if (fire) begin
            beat_cnt <= fin_beats;
         end
         case (state)
            ST_IDLE: if (fire && !s_tlast) state <= ST_BODY;
            ST_BODY: if (fin) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The slot accepts a new record when empty or being drained this cycle
   assign meta_load = fin && (!meta_valid || meta_ready);

   // One-entry metadata slot with sticky overflow flag
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         meta_valid  <= 1'b0;
         meta_q      <= '0;
         meta_bursts <= '0;
         meta_beats  <= '0;
         meta_drop   <= 1'b0;
      end else begin
         if (meta_load) begin
            meta_valid         <= 1'b1;
            meta_q.need_decomp <= fin_hdr.need_decomp;
            meta_q.len_err     <= fin_len_err;
            meta_q.length      <= fin_hdr.length;
            meta_bursts        <= CNT_W'(fin_bursts17);
            meta_beats         <= fin_beats;
         end else if (meta_valid && meta_ready) begin
            meta_valid <= 1'b0;
         end
         if (fin && !meta_load) begin
            meta_drop <= 1'b1;
         end
      end
   end

   assign meta_need_decomp = meta_q.need_decomp;
   assign meta_len_err     = meta_q.len_err;
   assign meta_length      = meta_q.length;

`ifdef PKT_CLS_STATS_EN
   // Wrap-around packet statistics; dropped records still count
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         stat_pkts   <= 32'd0;
         stat_decomp <= 32'd0;
         stat_lenerr <= 32'd0;
      end else if (fin) begin
         stat_pkts <= stat_pkts + 32'd1;
         if (fin_hdr.need_decomp) stat_decomp <= stat_decomp + 32'd1;
         if (fin_len_err)         stat_lenerr <= stat_lenerr + 32'd1;
      end
   end
`else
   assign stat_pkts   = 32'd0;
   assign stat_decomp = 32'd0;
   assign stat_lenerr = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_header_classifier.sv
// Scoreboard bench for pkt_header_classifier: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on each hdr pulse and
// each metadata handshake.
module tb_pkt_header_classifier;

   localparam int DATA_W = 256;
   localparam int CNT_W  = 16;

   logic              aclk;
   logic              aresetn;
   logic              s_tvalid;
   logic              s_tready;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tlast;
   logic              hdr_valid;
   logic              hdr_need_decomp;
   logic [15:0]       hdr_length;
   logic              meta_valid;
   logic              meta_ready;
   logic              meta_need_decomp;
   logic [15:0]       meta_length;
   logic [CNT_W-1:0]  meta_bursts;
   logic [CNT_W-1:0]  meta_beats;
   logic              meta_len_err;
   logic              meta_drop;
   logic [31:0]       stat_pkts;
   logic [31:0]       stat_decomp;
   logic [31:0]       stat_lenerr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        need;
      logic [15:0] len;
   } hdr_exp_t;

   typedef struct {
      logic        need;
      logic [15:0] len;
      logic [15:0] bursts;
      logic [15:0] beats;
      logic        err;
   } meta_exp_t;

   hdr_exp_t  hq[$];
   meta_exp_t mq[$];

   pkt_header_classifier #(
      .DATA_W      (DATA_W),
      .BURST_BYTES (32),
      .CNT_W       (CNT_W),
      .MATCH_IPLEN (1500),
      .FRAME_ADJ   (14)
   ) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .s_tdata          (s_tdata),
      .s_tlast          (s_tlast),
      .hdr_valid        (hdr_valid),
      .hdr_need_decomp  (hdr_need_decomp),
      .hdr_length       (hdr_length),
      .meta_valid       (meta_valid),
      .meta_ready       (meta_ready),
      .meta_need_decomp (meta_need_decomp),
      .meta_length      (meta_length),
      .meta_bursts      (meta_bursts),
      .meta_beats       (meta_beats),
      .meta_len_err     (meta_len_err),
      .meta_drop        (meta_drop),
      .stat_pkts        (stat_pkts),
      .stat_decomp      (stat_decomp),
      .stat_lenerr      (stat_lenerr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_beat();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DATA_W-1:0] mk_beat0(input logic [15:0] eth, input logic [7:0] tos,
                                                   input logic [7:0] proto, input logic [15:0] iplen);
      logic [DATA_W-1:0] d;
      d = rand_beat();
      d[8*12 +: 8] = eth[15:8];
      d[8*13 +: 8] = eth[7:0];
      d[8*15 +: 8] = tos;
      d[8*16 +: 8] = iplen[15:8];
      d[8*17 +: 8] = iplen[7:0];
      d[8*23 +: 8] = proto;
      return d;
   endfunction

   // One fired beat, optionally preceded by a stalled (tready=0) cycle that
   // carries tlast=1 so a DUT ignoring tready would misbehave.
   task automatic drive_beat(input logic [DATA_W-1:0] data, input logic last, input logic stall);
      if (stall) begin
         s_tvalid = 1'b1;
         s_tready = 1'b0;
         s_tlast  = 1'b1;
         s_tdata  = rand_beat();
         @(posedge aclk); #1;
      end
      s_tvalid = 1'b1;
      s_tready = 1'b1;
      s_tdata  = data;
      s_tlast  = last;
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drive_pkt(input logic [DATA_W-1:0] b0, input int nbeats, input logic terminate,
                            input int stall_at);
      for (int i = 0; i < nbeats; i++) begin
         drive_beat((i == 0) ? b0 : rand_beat(), terminate && (i == nbeats - 1), i == stall_at);
      end
   endtask

   task automatic send_pkt(input logic [15:0] eth, input logic [7:0] tos, input logic [7:0] proto,
                           input logic [15:0] iplen, input int nbeats,
                           input logic e_need, input logic [15:0] e_len, input logic [15:0] e_bursts,
                           input logic e_err, input logic push_meta, input int stall_at);
      hdr_exp_t  h;
      meta_exp_t m;
      h.need = e_need;
      h.len  = e_len;
      hq.push_back(h);
      if (push_meta) begin
         m.need   = e_need;
         m.len    = e_len;
         m.bursts = e_bursts;
         m.beats  = 16'(nbeats);
         m.err    = e_err;
         mq.push_back(m);
      end
      drive_pkt(mk_beat0(eth, tos, proto, iplen), nbeats, 1'b1, stall_at);
   endtask

   // Monitor: compare against the scoreboard whenever the DUT presents output
   always @(negedge aclk) begin
      if (aresetn) begin
         if (hdr_valid) begin
            if (hq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL hdr_unexpected: hdr_valid with no expected header at %0t", $time);
            end else begin
               hdr_exp_t h;
               h = hq.pop_front();
               chk("hdr_need_decomp", 32'(hdr_need_decomp), 32'(h.need));
               chk("hdr_length", 32'(hdr_length), 32'(h.len));
            end
         end
         if (meta_valid && meta_ready) begin
            if (mq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL meta_unexpected: meta handshake with no expected record at %0t", $time);
            end else begin
               meta_exp_t m;
               m = mq.pop_front();
               chk("meta_need_decomp", 32'(meta_need_decomp), 32'(m.need));
               chk("meta_length", 32'(meta_length), 32'(m.len));
               chk("meta_bursts", 32'(meta_bursts), 32'(m.bursts));
               chk("meta_beats", 32'(meta_beats), 32'(m.beats));
               chk("meta_len_err", 32'(meta_len_err), 32'(m.err));
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
      chk({tag, "_hdr_need"}, 32'(hdr_need_decomp), 32'd0);
      chk({tag, "_hdr_length"}, 32'(hdr_length), 32'd0);
      chk({tag, "_meta_valid"}, 32'(meta_valid), 32'd0);
      chk({tag, "_meta_length"}, 32'(meta_length), 32'd0);
      chk({tag, "_meta_bursts"}, 32'(meta_bursts), 32'd0);
      chk({tag, "_meta_beats"}, 32'(meta_beats), 32'd0);
      chk({tag, "_meta_drop"}, 32'(meta_drop), 32'd0);
      chk({tag, "_stat_pkts"}, stat_pkts, 32'd0);
   endtask

   initial begin
      int waited;
      aresetn    = 1'b0;
      s_tvalid   = 1'b0;
      s_tready   = 1'b1;
      s_tdata    = '0;
      s_tlast    = 1'b0;
      meta_ready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk_all_zero("reset");
      aresetn = 1'b1;

      // Two single-beat packets while the consumer is stalled: the second is dropped
      // IPv4 iplen 18 -> length 32, 1 burst, 1 beat expected, no match
      send_pkt(16'h0800, 8'h10, 8'h06, 16'd18, 1, 1'b0, 16'd32, 16'd1, 1'b0, 1'b1, -1);
      chk("single_hdr_valid", 32'(hdr_valid), 32'd1);
      chk("single_meta_valid", 32'(meta_valid), 32'd1);
      chk("drop_before", 32'(meta_drop), 32'd0);
      send_pkt(16'h86DD, 8'h00, 8'h00, 16'd0, 1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, -1);
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("held_meta_valid", 32'(meta_valid), 32'd1);
         chk("held_meta_length", 32'(meta_length), 32'd32);
         chk("held_meta_drop", 32'(meta_drop), 32'd1);
      end
`ifdef PKT_CLS_STATS_EN
      chk("stat_pkts_drop", stat_pkts, 32'd2);
`else
      chk("stat_pkts_off", stat_pkts, 32'd0);
`endif
      @(posedge aclk); #1;
      meta_ready = 1'b1;

      // Main classification cases, back to back; first one has a stall cycle
      send_pkt(16'h0800, 8'h10, 8'h06, 16'd1500, 48, 1'b1, 16'd1514, 16'd48, 1'b0, 1'b1, 10);
      send_pkt(16'h0800, 8'h00, 8'h06, 16'd1500, 48, 1'b0, 16'd1514, 16'd48, 1'b0, 1'b1, -1);
      send_pkt(16'h0800, 8'h10, 8'h11, 16'd1500, 48, 1'b0, 16'd1514, 16'd48, 1'b0, 1'b1, -1);
      send_pkt(16'h0800, 8'h10, 8'h06, 16'd1000, 32, 1'b0, 16'd1014, 16'd32, 1'b0, 1'b1, -1);
      send_pkt(16'h86DD, 8'h10, 8'h06, 16'd1500, 3,  1'b0, 16'd0,    16'd0,  1'b0, 1'b1, -1);
      send_pkt(16'h0800, 8'h10, 8'h06, 16'd1500, 40, 1'b1, 16'd1514, 16'd48, 1'b1, 1'b1, -1);
      repeat (3) @(posedge aclk);
      #1;

      // Abort a packet after beat 4 with reset; no record may appear for it
      begin
         hdr_exp_t h;
         h.need = 1'b1;
         h.len  = 16'd1514;
         hq.push_back(h);
      end
      drive_pkt(mk_beat0(16'h0800, 8'h10, 8'h06, 16'd1500), 5, 1'b0, -1);
      aresetn = 1'b0;
      @(posedge aclk); #1;
      chk_all_zero("midrst");
      @(posedge aclk); #1;
      chk_all_zero("midrst2");
      aresetn = 1'b1;

      // New packet after reset, then a short IPv4 packet cut to one beat
      send_pkt(16'h0800, 8'h01, 8'h06, 16'd1500, 48, 1'b1, 16'd1514, 16'd48, 1'b0, 1'b1, -1);
      send_pkt(16'h0800, 8'h10, 8'h06, 16'd46,   1,  1'b0, 16'd60,   16'd2,  1'b1, 1'b1, -1);

      waited = 0;
      while ((hq.size() != 0 || mq.size() != 0) && waited < 200) begin
         @(posedge aclk);
         waited++;
      end
      #1;
      checks++;
      if (hq.size() != 0 || mq.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d hdr and %0d meta expectations still pending, required 0", hq.size(), mq.size());
      end
`ifdef PKT_CLS_STATS_EN
      chk("stat_pkts_end", stat_pkts, 32'd2);
      chk("stat_decomp_end", stat_decomp, 32'd1);
      chk("stat_lenerr_end", stat_lenerr, 32'd1);
`else
      chk("stat_decomp_off", stat_decomp, 32'd0);
      chk("stat_lenerr_off", stat_lenerr, 32'd0);
`endif
      chk("meta_valid_idle", 32'(meta_valid), 32'd0);
      chk("meta_drop_after_reset", 32'(meta_drop), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
